// File: rtl/spi_reg_sched_pkg.sv
// rtl/spi_reg_sched_pkg.sv - opcodes, FSM state encoding and address width for spi_reg_sched
package spi_reg_sched_pkg;

  localparam int ADDR_W = 5;

  localparam logic [7:0] OP_RD = 8'hF0;
  localparam logic [7:0] OP_WR = 8'hF1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_FETCH  = 3'd1,
    RD_WAIT   = 3'd2,
    WR_DATA   = 3'd3,
    WR_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-way round-robin arbiter (SPI engine vs local requester)
module spi_rr_arb2 (
  input  logic i_clk,
  input  logic rst,
  input  logic req_spi,
  input  logic req_loc,
  output logic gnt_spi,
  output logic gnt_loc
);

  // prio_loc set means SPI was granted last, so the local side wins a tie
  logic prio_loc;

  always_comb begin
    gnt_spi = req_spi & (~req_loc | ~prio_loc);
    gnt_loc = req_loc & (~req_spi | prio_loc);
    if (rst) begin
      gnt_spi = 1'b0;
      gnt_loc = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)          prio_loc <= 1'b0;
    else if (gnt_spi) prio_loc <= 1'b1;
    else if (gnt_loc) prio_loc <= 1'b0;
  end

endmodule

// File: rtl/spi_reg_sched.sv
// rtl/spi_reg_sched.sv - SPI command engine and local requester sharing one register bank
// Optional sticky o_err output under `define SPI_REG_SCHED_ERR_EN.
module spi_reg_sched
  import spi_reg_sched_pkg::*;
#(
  parameter int BURST_LEN = 5,
  parameter int NREG      = 32
) (
  input  logic              i_clk,
  input  logic              rst,
  input  logic              rec_done,
  input  logic [15:0]       rec_data,
  input  logic              transmit_done,
  output logic [15:0]       data_in,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [15:0]       loc_wdata,
  output logic              loc_gnt,
  output logic [15:0]       loc_rdata
`ifdef SPI_REG_SCHED_ERR_EN
  ,
  output logic              o_err
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [15:0]         wdata, wdata_n;
  logic [15:0]         bank [NREG];
  logic                spi_req, spi_gnt, loc_gnt_c, drop_err;
  logic                unused_sig;

  spi_rr_arb2 u_arb (
    .i_clk   (i_clk),
    .rst     (rst),
    .req_spi (spi_req),
    .req_loc (loc_req),
    .gnt_spi (spi_gnt),
    .gnt_loc (loc_gnt_c)
  );

  assign loc_gnt    = loc_gnt_c;
  assign unused_sig = ^{rec_data[7:ADDR_W], drop_err};

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    cnt_n    = cnt;
    wdata_n  = wdata;
    spi_req  = 1'b0;
    drop_err = 1'b0;
    case (state)
      IDLE: begin
        if (rec_done) begin
          if (rec_data[15:8] == OP_RD) begin
            addr_n  = rec_data[ADDR_W-1:0];
            cnt_n   = '0;
            state_n = RD_FETCH;
          end else if (rec_data[15:8] == OP_WR) begin
            addr_n  = rec_data[ADDR_W-1:0];
            state_n = WR_DATA;
          end else begin
            drop_err = 1'b1;
          end
        end
      end
      RD_FETCH: begin
        spi_req = 1'b1;
        if (spi_gnt) state_n = RD_WAIT;
      end
      // rec_done during a burst carries only dummy words
      RD_WAIT: begin
        if (transmit_done) begin
          cnt_n   = cnt + CNT_W'(1);
          addr_n  = addr + ADDR_W'(1);
          state_n = (cnt_n == CNT_LAST) ? IDLE : RD_FETCH;
        end
      end
      WR_DATA: begin
        if (rec_done) begin
          wdata_n = rec_data;
          state_n = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        spi_req  = 1'b1;
        drop_err = rec_done;
        if (spi_gnt) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      cnt       <= '0;
      wdata     <= '0;
      data_in   <= '0;
      loc_rdata <= '0;
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      addr  <= addr_n;
      cnt   <= cnt_n;
      wdata <= wdata_n;
      if (spi_gnt) begin
        if (state == WR_COMMIT) bank[addr] <= wdata;
        else                    data_in    <= bank[addr];
      end else if (loc_gnt_c) begin
        if (loc_we) bank[loc_addr] <= loc_wdata;
        else        loc_rdata      <= bank[loc_addr];
      end
    end
  end

`ifdef SPI_REG_SCHED_ERR_EN
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)           o_err <= 1'b0;
    else if (drop_err) o_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_reg_sched.sv
// tb/tb_spi_reg_sched.sv - directed self-checking bench for spi_reg_sched
module tb_spi_reg_sched;

  localparam int BL = 5;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_done = 1'b0;
  logic [15:0] rec_data = '0;
  logic        transmit_done = 1'b0;
  logic [15:0] data_in;
  logic        loc_req = 1'b0;
  logic        loc_we = 1'b0;
  logic [4:0]  loc_addr = '0;
  logic [15:0] loc_wdata = '0;
  logic        loc_gnt;
  logic [15:0] loc_rdata;
`ifdef SPI_REG_SCHED_ERR_EN
  logic        o_err;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] model [32];
  logic [15:0] exp_din = '0;

  spi_reg_sched #(.BURST_LEN(BL), .NREG(32)) dut (
    .i_clk         (i_clk),
    .rst           (rst),
    .rec_done      (rec_done),
    .rec_data      (rec_data),
    .transmit_done (transmit_done),
    .data_in       (data_in),
    .loc_req       (loc_req),
    .loc_we        (loc_we),
    .loc_addr      (loc_addr),
    .loc_wdata     (loc_wdata),
    .loc_gnt       (loc_gnt),
    .loc_rdata     (loc_rdata)
`ifdef SPI_REG_SCHED_ERR_EN
    ,
    .o_err         (o_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic loc_access(input logic we, input logic [4:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge i_clk);
    loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    #1;
    while (!loc_gnt && n < 20) begin
      @(negedge i_clk); #1;
      n++;
    end
    check("loc_gnt_wait", loc_gnt, 1);
    @(negedge i_clk);
    loc_req = 1'b0; loc_we = 1'b0;
    if (we) model[a] = d;
  endtask

  task automatic spi_word(input logic [15:0] w);
    @(negedge i_clk);
    rec_done = 1'b1; rec_data = w;
    @(negedge i_clk);
    rec_done = 1'b0;
  endtask

  task automatic pulse_td(input logic dummy);
    @(negedge i_clk);
    transmit_done = 1'b1;
    rec_done = dummy; rec_data = 16'hF105;
    @(negedge i_clk);
    transmit_done = 1'b0; rec_done = 1'b0;
  endtask

  task automatic burst_tail(input logic [4:0] a, input logic dummy);
    logic [4:0] ak;
    for (int k = 1; k < BL; k++) begin
      pulse_td(dummy);
      @(negedge i_clk);
      ak = a + 5'(k);
      exp_din = model[ak];
      check($sformatf("burst_word%0d_a%0d", k, ak), data_in, exp_din);
    end
    pulse_td(dummy);
  endtask

  task automatic read_burst(input logic [4:0] a, input logic dummy);
    spi_word({8'hF0, 3'b000, a});
    check("rd_latency_hold", data_in, exp_din);
    @(negedge i_clk);
    exp_din = model[a];
    check($sformatf("burst_word0_a%0d", a), data_in, exp_din);
    burst_tail(a, dummy);
    pulse_td(1'b0);
    @(negedge i_clk);
    check("idle_hold", data_in, exp_din);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(negedge i_clk);
    loc_req = 1'b1; #1;
    check("rst_data_in", data_in, 0);
    check("rst_loc_gnt", loc_gnt, 0);
    check("rst_loc_rdata", loc_rdata, 0);
`ifdef SPI_REG_SCHED_ERR_EN
    check("rst_o_err", o_err, 0);
`endif
    @(negedge i_clk);
    loc_req = 1'b0; rst = 1'b0;

    loc_access(1'b1, 5'd3, 16'h1234);
    for (int i = 4; i < 8; i++) loc_access(1'b1, 5'(i), 16'hA000 + 16'(i));
    loc_access(1'b1, 5'd0, 16'hA000);
    loc_access(1'b1, 5'd1, 16'hA001);
    loc_access(1'b1, 5'd2, 16'hA002);
    loc_access(1'b1, 5'd30, 16'hA01E);
    loc_access(1'b1, 5'd31, 16'hA01F);
    loc_access(1'b0, 5'd3, 16'h0);
    check("loc_read_3", loc_rdata, 16'h1234);

    read_burst(5'd3, 1'b0);
    read_burst(5'd30, 1'b1);

    // SPI was granted last, so a fresh tie goes to the local side
    spi_word(16'hF000);
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 5'd4; #1;
    check("rr_loc_first", loc_gnt, 1);
    @(negedge i_clk); #1;
    check("rr_spi_next", loc_gnt, 0);
    check("rr_spi_wait_din", data_in, exp_din);
    @(negedge i_clk); #1;
    exp_din = model[0];
    check("rr_word0", data_in, exp_din);
    check("rr_loc_again", loc_gnt, 1);
    check("rr_loc_rdata", loc_rdata, 16'hA004);
    loc_req = 1'b0;
    burst_tail(5'd0, 1'b0);

    spi_word(16'hF105);
    spi_word(16'hBEEF);
    rec_done = 1'b1; rec_data = 16'hF01F;
    @(negedge i_clk);
    rec_done = 1'b0;
    repeat (2) @(negedge i_clk);
    check("wr_commit_drop", data_in, exp_din);
    model[5] = 16'hBEEF;
    loc_access(1'b0, 5'd5, 16'h0);
    check("spi_write_5", loc_rdata, 16'hBEEF);
`ifdef SPI_REG_SCHED_ERR_EN
    check("err_on_drop", o_err, 1);
`endif

    spi_word(16'hF003);
    @(negedge i_clk);
    check("rdwait_before_rst", data_in, 16'h1234);
    rst = 1'b1; #1;
    check("rdwait_rst_din", data_in, 0);
    check("rdwait_rst_rdata", loc_rdata, 0);
    @(negedge i_clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_din = '0;
    pulse_td(1'b0);
    @(negedge i_clk);
    check("post_rst_idle", data_in, 0);

    spi_word(16'hF107);
    spi_word(16'h9999);
    rst = 1'b1; #1;
    check("wrcommit_rst_din", data_in, 0);
    check("wrcommit_rst_gnt", loc_gnt, 0);
    @(negedge i_clk);
    rst = 1'b0;
    loc_access(1'b0, 5'd7, 16'h0);
    check("wrcommit_no_write", loc_rdata, 0);
    spi_word(16'hF107);
    spi_word(16'h4321);
    @(negedge i_clk);
    loc_access(1'b0, 5'd7, 16'h0);
    check("new_cmd_after_rst", loc_rdata, 16'h4321);

`ifdef SPI_REG_SCHED_ERR_EN
    @(negedge i_clk); rst = 1'b1;
    @(negedge i_clk); rst = 1'b0;
    check("err_cleared", o_err, 0);
    spi_word(16'h7700);
    check("err_unknown_op", o_err, 1);
    repeat (3) @(negedge i_clk);
    check("err_sticky", o_err, 1);
    rst = 1'b1; #1;
    check("err_rst", o_err, 0);
    @(negedge i_clk); rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
